data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, the address width.
REQ-003 SHALL have parameter DEPTH, default 8, the number of implemented data-memory words (valid addresses 0..DEPTH-1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports rN_req, input, 1, per requester N in {0,1}; the requester holds it high with a stable command until it sees rN_gnt.
REQ-007 SHALL have ports rN_we, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have ports rN_addr, input, ADDR_W, the word address.
REQ-009 SHALL have ports rN_wdata, input, DATA_W, the write data.
REQ-010 SHALL have ports rN_gnt, output, 1, a one-cycle pulse marking that the command is being executed this cycle.
REQ-011 SHALL have ports rN_rvalid, output, 1, a one-cycle read-response pulse.
REQ-012 SHALL have ports rN_rdata, output, DATA_W, the read data, qualified by rN_rvalid.
REQ-013 SHALL have ports rN_err, output, 1, an out-of-range pulse coincident with the response slot.
REQ-014 SHALL have port mem_access_addr, output, ADDR_W, driven to the memory.
REQ-015 SHALL have port mem_write_data, output, DATA_W, driven to the memory.
REQ-016 SHALL have ports mem_write_en and mem_read, output, 1 each, driven to the memory.
REQ-017 SHALL have port mem_read_data, input, DATA_W, the combinational read data from the memory.

Function
REQ-018 SHALL implement FSM states IDLE and ACCESS. Transitions: IDLE -> ACCESS when any req is high at the clock edge; ACCESS -> IDLE unconditionally.
REQ-019 SHALL, at the IDLE->ACCESS edge, latch the winner's we, addr and wdata into command registers and record the winner as owner.
REQ-020 SHALL arbitrate round-robin: when both req are high, the winner is the requester that is not last_owner; a single request always wins; last_owner updates on every grant.
REQ-021 SHALL, in ACCESS, assert owner's gnt, drive mem_access_addr and mem_write_data from the command registers, and set mem_write_en = we and mem_read = ~we, gated by the range check.
REQ-022 SHALL treat an address >= DEPTH as out of range: no memory strobes; the response slot carries err = 1, with rdata = 0 for reads.
REQ-023 SHALL, at the ACCESS->IDLE edge of a read, register mem_read_data (or 0 if out of range) into the owner's rdata, and pulse rvalid in the following cycle.
REQ-024 SHALL pulse err in the cycle after ACCESS for both reads and writes; writes produce no rvalid.
REQ-025 SHALL give a latency of: req sampled at edge E; gnt during cycle E..E+1; rvalid/err during cycle E+1..E+2; throughput of at most one access per 2 cycles.
REQ-026 SHALL hold rN_rdata until the next read response to that requester.
REQ-027 SHALL NOT sample requests during ACCESS, so a requester dropping req one cycle after gnt is never double-granted.
REQ-028 SHALL, when a req is withdrawn before grant, drop it with no side effect.
REQ-029 SHALL keep all mem_* outputs at 0 in IDLE.

Reset
REQ-030 SHALL, while rst is high, immediately force state IDLE, last_owner = 1 (requester 0 wins the first tie), and all outputs and command registers to 0.
REQ-031 SHALL, if rst asserts during ACCESS, deassert mem_write_en asynchronously so that no write commits; no rvalid or err follows.

Verification
REQ-032 SHALL verify single write then read: r0 write addr 3 data 0xBEEF, then r0 read addr 3 -> r0_gnt one cycle each; r0_rvalid with r0_rdata = 0xBEEF two cycles after req sampled.
REQ-033 SHALL verify tie after reset: r0 and r1 both read in the same cycle -> r0 granted first, r1 granted 2 cycles later; each receives its own rvalid and no cross-delivery.
REQ-034 SHALL verify sustained contention: both req held high for 8 grants -> grants alternate r0,r1,r0,r1,...; no two consecutive grants to one requester.
REQ-035 SHALL verify out of range: r1 read addr 8 with DEPTH 8 -> mem_read stays 0; r1_err and r1_rvalid pulse; r1_rdata = 0.
REQ-036 SHALL verify reset mid-write: rst pulsed during ACCESS of r0 write addr 5 data 0x1234 -> memory[5] unchanged; all outputs 0 during reset.
REQ-037 SHALL verify a request withdrawn before grant: r1 req high for one cycle while r0 owns ACCESS, then low -> r1 never granted; no memory strobe for r1.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One access every two cycles: IDLE samples requests, ACCESS drives the
// memory, and the response (rvalid/err/rdata) lands in the following cycle.

// Per-requester response register: captures the read result or range error
// on the ACCESS->IDLE edge and presents it for one cycle.
module data_mem_arbiter_lane #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              rd_op,
  input  logic              oor,
  input  logic [DATA_W-1:0] rd_in,
  output logic              rvalid,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);
  // Response pulses last one cycle; rdata holds until the next read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= load & rd_op;
      err    <= load & oor;
      if (load & rd_op) rdata <= oor ? '0 : rd_in;
    end
  end
endmodule

module data_mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);
  localparam logic       IDLE   = 1'b0;
  localparam logic       ACCESS = 1'b1;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic              state;
  logic              owner;
  logic              last_owner;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic [1:0]             req;
  logic                   winner;
  logic                   access;
  logic                   oor;
  logic [1:0]             gnt;
  logic [1:0]             rvalid;
  logic [1:0]             err;
  logic [1:0][DATA_W-1:0] rdata;

  assign req    = {r1_req, r0_req};
  assign access = (state == ACCESS);
  assign oor    = ({1'b0, cmd_addr} >= DEPTH_V);

  // Round-robin pick: on a tie the requester that did not go last wins.
  always_comb begin
    winner = req[1];
    if (&req) winner = ~last_owner;
  end

  // Two-state FSM; requests are only looked at in IDLE, so a requester
  // still holding req in the grant cycle cannot be granted twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state      <= ACCESS;
          owner      <= winner;
          last_owner <= winner;
          cmd_we     <= winner ? r1_we    : r0_we;
          cmd_addr   <= winner ? r1_addr  : r0_addr;
          cmd_wdata  <= winner ? r1_wdata : r0_wdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side is quiet outside ACCESS; out-of-range commands get no
  // strobes. rst gates the write strobe directly so a reset mid-ACCESS
  // can never let the write commit.
  assign mem_access_addr = access ? cmd_addr  : '0;
  assign mem_write_data  = access ? cmd_wdata : '0;
  assign mem_write_en    = access & cmd_we  & ~oor & ~rst;
  assign mem_read        = access & ~cmd_we & ~oor;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign gnt[i] = access && (owner == 1'(i));
    data_mem_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (gnt[i]),
      .rd_op  (~cmd_we),
      .oor    (oor),
      .rd_in  (mem_read_data),
      .rvalid (rvalid[i]),
      .err    (err[i]),
      .rdata  (rdata[i])
    );
  end

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign r0_rvalid = rvalid[0];
  assign r1_rvalid = rvalid[1];
  assign r0_err    = err[0];
  assign r1_err    = err[1];
  assign r0_rdata  = rdata[0];
  assign r1_rdata  = rdata[1];
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural memory and a
// per-requester scoreboard of expected responses.
module tb_data_mem_arbiter;
  localparam int DW = 16, AW = 16, DEPTH = 8;

  typedef struct packed {
    logic          rv;
    logic          er;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] mem_access_addr;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic          mem_write_en, mem_read;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          mem_init;

  exp_t q0[$];
  exp_t q1[$];
  int   glog[$];
  int   checks = 0;
  int   errors = 0;

  data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the rising edge.
  assign mem_read_data = (mem_access_addr < AW'(DEPTH)) ? mem[mem_access_addr[2:0]] : '0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(16'hA000 + i);
    end else if (mem_write_en && mem_access_addr < AW'(DEPTH)) begin
      mem[mem_access_addr[2:0]] <= mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop and compare one response for requester n if the DUT produced one.
  task automatic mon(input int n, input logic rv, input logic er, input logic [DW-1:0] rd);
    exp_t e;
    if (!(rv || er)) return;
    if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
      chk($sformatf("r%0d_unexpected_resp", n), {rv, er}, 2'b00);
      return;
    end
    e = (n == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("r%0d_rvalid", n), rv, e.rv);
    chk($sformatf("r%0d_err", n), er, e.er);
    if (e.rv) chk($sformatf("r%0d_rdata", n), rd, e.d);
  endtask

  // Advance to the next falling edge and run the response scoreboard.
  task automatic tick();
    @(negedge clk);
    if (r0_gnt) glog.push_back(0);
    if (r1_gnt) glog.push_back(1);
    mon(0, r0_rvalid, r0_err, r0_rdata);
    mon(1, r1_rvalid, r1_err, r1_rdata);
  endtask

  // Expected response for a command, derived from the reference memory.
  task automatic expect_cmd(input int n, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    logic oor;
    oor = (a >= AW'(DEPTH));
    e.rv = ~we;
    e.er = oor;
    e.d  = (oor || we) ? '0 : ref_mem[a[2:0]];
    if (we && !oor) ref_mem[a[2:0]] = d;
    if (e.rv || e.er) begin
      if (n == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Issue one command from requester n (called at a falling edge); returns
  // at the falling edge inside the grant cycle with req already dropped.
  task automatic do_req(input int n, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat);
    expect_cmd(n, we, a, d);
    if (n == 0) begin r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = d; end
    else        begin r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = d; end
    lat = 0;
    do begin tick(); lat++; end while (!(n == 0 ? r0_gnt : r1_gnt) && lat < 20);
    chk($sformatf("r%0d_gnt_seen", n), (n == 0 ? r0_gnt : r1_gnt), 1'b1);
    if (n == 0) r0_req = 0; else r1_req = 0;
  endtask

  function automatic logic [127:0] outs();
    return {r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err, r0_rdata, r1_rdata,
            mem_access_addr, mem_write_data, mem_write_en, mem_read};
  endfunction

  initial begin
    int lat, t0, t1, c, gcount;
    logic bad;
    rst = 1; mem_init = 1;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(16'hA000 + i);
    tick(); tick();
    chk("reset_outputs_zero", outs(), '0);
    mem_init = 0; rst = 0;
    tick();
    chk("idle_outputs_zero", outs(), '0);

    // Tie right after reset: r0 wins, r1 follows two cycles later.
    expect_cmd(0, 0, 16'd1, '0);
    expect_cmd(1, 0, 16'd2, '0);
    r0_req = 1; r0_we = 0; r0_addr = 16'd1;
    r1_req = 1; r1_we = 0; r1_addr = 16'd2;
    t0 = -1; t1 = -1; c = 0;
    while ((t0 < 0 || t1 < 0) && c < 20) begin
      tick(); c++;
      if (r0_gnt && r1_gnt) chk("tie_both_gnt", 1'b1, 1'b0);
      if (r0_gnt) begin t0 = c; r0_req = 0; end
      if (r1_gnt) begin t1 = c; r1_req = 0; end
    end
    chk("tie_r0_first", t0, 1);
    chk("tie_r1_two_later", t1, 3);
    tick(); tick();

    // Write then read back at the same address.
    do_req(0, 1, 16'd3, 16'hBEEF, lat);
    chk("wr_gnt_latency", lat, 1);
    chk("wr_strobe", {mem_write_en, mem_read, mem_access_addr, mem_write_data},
        {1'b1, 1'b0, 16'd3, 16'hBEEF});
    tick();
    chk("wr_gnt_one_pulse", {r0_gnt, r0_rvalid, r0_err}, 3'b000);
    do_req(0, 0, 16'd3, '0, lat);
    chk("rd_gnt_latency", lat, 1);
    chk("rd_strobe", {mem_write_en, mem_read}, 2'b01);
    tick();
    chk("rd_rvalid_latency", r0_rvalid, 1'b1);
    chk("rd_gnt_one_pulse", r0_gnt, 1'b0);

    // r0_rdata must hold across another requester's read.
    do_req(1, 0, 16'd2, '0, lat);
    tick(); tick(); tick();
    chk("r0_rdata_hold", r0_rdata, 16'hBEEF);
    chk("mem3_written", mem[3], 16'hBEEF);

    // Sustained contention: both held high for 8 grants.
    for (int i = 0; i < 4; i++) begin
      expect_cmd(0, 0, 16'd1, '0);
      expect_cmd(1, 0, 16'd6, '0);
    end
    glog.delete();
    r0_req = 1; r0_we = 0; r0_addr = 16'd1;
    r1_req = 1; r1_we = 0; r1_addr = 16'd6;
    gcount = 0; c = 0;
    while (gcount < 8 && c < 40) begin
      tick(); c++;
      if (r0_gnt || r1_gnt) gcount++;
    end
    r0_req = 0; r1_req = 0;
    tick(); tick(); tick();
    chk("cont_grant_count", glog.size(), 8);
    if (glog.size() > 0) chk("cont_first_r0", glog[0], 0);
    for (int i = 1; i < glog.size(); i++)
      chk($sformatf("cont_alternate_%0d", i), glog[i], 1 - glog[i-1]);

    // Range boundaries: last valid word, then one past the end.
    do_req(1, 0, 16'd7, '0, lat);
    chk("addr7_read_strobe", mem_read, 1'b1);
    tick(); tick();
    do_req(1, 0, 16'd8, '0, lat);
    chk("oor_read_no_strobe", {mem_read, mem_write_en}, 2'b00);
    tick();
    chk("oor_read_resp", {r1_rvalid, r1_err, r1_rdata}, {1'b1, 1'b1, 16'h0000});
    tick();
    do_req(0, 1, 16'd9, 16'h5555, lat);
    chk("oor_write_no_strobe", {mem_read, mem_write_en}, 2'b00);
    tick();
    chk("oor_write_err_only", {r0_rvalid, r0_err}, 2'b01);
    tick();

    // r1 raises req only while r0 owns ACCESS, then withdraws it.
    do_req(0, 0, 16'd4, '0, lat);
    r1_req = 1; r1_we = 1; r1_addr = 16'd2; r1_wdata = 16'hDEAD;
    tick();
    r1_req = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (r1_gnt || mem_read || mem_write_en) bad = 1;
    end
    chk("withdrawn_never_granted", bad, 1'b0);
    chk("withdrawn_mem2_unchanged", mem[2], ref_mem[2]);

    // Reset pulsed during ACCESS of a write: nothing commits.
    r0_req = 1; r0_we = 1; r0_addr = 16'd5; r0_wdata = 16'h1234;
    tick();
    chk("rstmid_in_access", {r0_gnt, mem_write_en}, 2'b11);
    #1 rst = 1; r0_req = 0;
    #1 chk("rstmid_outputs_zero", outs(), '0);
    tick();
    chk("rstmid_held_zero", outs(), '0);
    rst = 0;
    tick(); tick();
    chk("rstmid_mem5_unchanged", mem[5], ref_mem[5]);
    chk("rstmid_no_resp", {r0_rvalid, r0_err, r1_rvalid, r1_err}, 4'b0000);

    // Last-owner reset: tie goes to r0 again.
    expect_cmd(0, 0, 16'd0, '0);
    expect_cmd(1, 0, 16'd0, '0);
    r0_req = 1; r0_addr = 16'd0; r0_we = 0;
    r1_req = 1; r1_addr = 16'd0; r1_we = 0;
    tick();
    chk("post_reset_tie_r0", {r0_gnt, r1_gnt}, 2'b10);
    r0_req = 0;
    tick(); tick();
    chk("post_reset_tie_r1", r1_gnt, 1'b1);
    r1_req = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
